// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake, registered result and flags.
// Optional shift-add multiplier is built only when ALU_MUL_EN is defined.
module alu_mc #(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  src1,
  input  logic [WIDTH-1:0]  src2,
  input  logic [CTRL_W-1:0] ALUcontrol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  Result,
  output logic              Zero,
  output logic              Overflow,
  output logic              Illegal
);

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_NOR = CTRL_W'(4'b1100);

  logic             accept;
  logic [WIDTH-1:0] sum, diff, res1;
  logic             ov1, ill1, slt;

`ifdef ALU_MUL_EN
  localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(4'b1000);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic               is_mul;

  assign is_mul   = (ALUcontrol == OP_MUL);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    sum  = src1 + src2;
    diff = src1 - src2;
    slt  = $signed(src1) < $signed(src2);
    res1 = '0;
    ov1  = 1'b0;
    ill1 = 1'b0;
    case (ALUcontrol)
      OP_AND: res1 = src1 & src2;
      OP_OR:  res1 = src1 | src2;
      OP_ADD: begin
        res1 = sum;
        ov1  = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        res1 = diff;
        ov1  = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SLT: res1 = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR: res1 = ~(src1 | src2);
`ifdef ALU_MUL_EN
      OP_MUL: res1 = '0;
`endif
      default: ill1 = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      // In MUL, out_valid is already low: a MUL is only accepted into an empty or draining output.
      if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
        if (count == CW'(1)) begin
          Result    <= acc_next[WIDTH-1:0];
          Zero      <= (acc_next[WIDTH-1:0] == '0);
          Overflow  <= |acc_next[2*WIDTH-1:WIDTH];
          Illegal   <= 1'b0;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
      end else if (accept && is_mul) begin
        acc       <= '0;
        mcand     <= {{WIDTH{1'b0}}, src1};
        mplier    <= src2;
        count     <= CW'(WIDTH);
        out_valid <= 1'b0;
        state     <= MUL;
      end else
`endif
      if (accept) begin
        Result    <= res1;
        Zero      <= (res1 == '0);
        Overflow  <= ov1;
        Illegal   <= ill1;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table through a scoreboard plus
// latency, backpressure and reset corner sequences. Honours ALU_MUL_EN.
module tb_alu_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         Zero, Overflow, Illegal;
  logic [W-1:0] src1, src2, Result;
  logic [3:0]   ALUcontrol;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .ALUcontrol(ALUcontrol),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         ill;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [W-1:0] res, logic z, logic ov, logic ill);
    exp_t e;
    e.res = res; e.z = z; e.ov = ov; e.ill = ill;
    return e;
  endfunction

  function automatic void add_vec(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, exp_t e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.e = e;
    vt.push_back(v);
  endfunction

  // Results are compared when the consumer takes them.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", Result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", Result, e.res);
        chk("sb_zero", Zero, e.z);
        chk("sb_overflow", Overflow, e.ov);
        chk("sb_illegal", Illegal, e.ill);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int n;
    n = 0;
    ALUcontrol = op; src1 = a; src2 = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    src1       = W'($urandom);
    src2       = W'($urandom);
    ALUcontrol = 4'($urandom);
  endtask

  initial begin
    int   cyc;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; ALUcontrol = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", Result, 0);
    chk("reset_zero", Zero, 0);
    chk("reset_overflow", Overflow, 0);
    chk("reset_illegal", Illegal, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);

    add_vec(4'b0000, 16'hF0F0, 16'h0FF0, mk(16'h00F0, 0, 0, 0));
    add_vec(4'b0001, 16'hF000, 16'h000F, mk(16'hF00F, 0, 0, 0));
    add_vec(4'b0010, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 1, 0));
    add_vec(4'b0010, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 0, 0));
    add_vec(4'b0010, 16'h8000, 16'h8000, mk(16'h0000, 1, 1, 0));
    add_vec(4'b0110, 16'h0005, 16'h0005, mk(16'h0000, 1, 0, 0));
    add_vec(4'b0110, 16'h8000, 16'h0001, mk(16'h7FFF, 0, 1, 0));
    add_vec(4'b0110, 16'h7FFF, 16'hFFFF, mk(16'h8000, 0, 1, 0));
    add_vec(4'b0111, 16'hFFFF, 16'h0001, mk(16'h0001, 0, 0, 0));
    add_vec(4'b0111, 16'h0001, 16'hFFFF, mk(16'h0000, 1, 0, 0));
    add_vec(4'b0111, 16'h8000, 16'h7FFF, mk(16'h0001, 0, 0, 0));
    add_vec(4'b1100, 16'h00FF, 16'h0F00, mk(16'hF000, 0, 0, 0));
    add_vec(4'b1100, 16'hFFFF, 16'h0000, mk(16'h0000, 1, 0, 0));
    add_vec(4'b1111, 16'h1234, 16'h5678, mk(16'h0000, 1, 0, 1));
    add_vec(4'b0011, 16'hFFFF, 16'hFFFF, mk(16'h0000, 1, 0, 1));
`ifdef ALU_MUL_EN
    add_vec(4'b1000, 16'd300,  16'd200,  mk(16'hEA60, 0, 0, 0));
    add_vec(4'b1000, 16'h0100, 16'h0100, mk(16'h0000, 1, 1, 0));
    add_vec(4'b1000, 16'hFFFF, 16'hFFFF, mk(16'h0001, 0, 1, 0));
    add_vec(4'b1000, 16'h0000, 16'h1234, mk(16'h0000, 1, 0, 0));
    add_vec(4'b0010, 16'h0003, 16'h0004, mk(16'h0007, 0, 0, 0));
`else
    add_vec(4'b1000, 16'd300,  16'd200,  mk(16'h0000, 1, 0, 1));
`endif

    for (int i = 0; i < vt.size(); i++)
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].e);

    // Single-cycle latency from an idle output.
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);
    send(4'b0010, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 1, 0));
    chk("add_latency_valid", out_valid, 1);
    chk("add_latency_result", Result, 16'h8000);

`ifdef ALU_MUL_EN
    send(4'b1000, 16'd300, 16'd200, mk(16'hEA60, 0, 0, 0));
    cyc = 0; seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mul_latency", cyc, W);
    chk("mul_in_ready_low", seen, 0);
`else
    send(4'b1000, 16'h0100, 16'h0100, mk(16'h0000, 1, 0, 1));
    chk("mul_disabled_latency", out_valid, 1);
    chk("mul_disabled_illegal", Illegal, 1);
`endif

    // Backpressure: hold the AND result, then drain it while accepting an OR.
    send(4'b0000, 16'hF0F0, 16'h0FF0, mk(16'h00F0, 0, 0, 0));
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", Result, 16'h00F0);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    send(4'b0001, 16'h1200, 16'h0034, mk(16'h1234, 0, 0, 0));
    chk("no_bubble_valid", out_valid, 1);
    chk("no_bubble_result", Result, 16'h1234);

    // Reset with work in flight: nothing from before reset may emerge.
`ifdef ALU_MUL_EN
    send(4'b1000, 16'h1234, 16'h0002, mk(16'h2468, 0, 0, 0));
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
`else
    send(4'b0010, 16'h0001, 16'h0001, mk(16'h0002, 0, 0, 0));
    out_ready = 1'b0;
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_result", Result, 0);
    chk("rst_mid_zero", Zero, 0);
    chk("rst_mid_overflow", Overflow, 0);
    chk("rst_mid_illegal", Illegal, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_stale", seen, 0);

    send(4'b0110, 16'h0005, 16'h0005, mk(16'h0000, 1, 0, 0));

    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
